// File: rtl/rr_arb_mux_pkg.sv
// rtl/rr_arb_mux_pkg.sv - shared arbitration constants and select-width helper
package rr_arb_mux_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    // Width of a channel index; never narrower than one bit.
    function automatic int sel_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arb_mux_if.sv
// rtl/rr_arb_mux_if.sv - channel-side and downstream handshake bundle
interface rr_arb_mux_if
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 4
);
    localparam int SEL_W = sel_w(NUM_CH);

    logic                      flush;
    logic [NUM_CH-1:0]         in_valid;
    logic [NUM_CH*WIDTH-1:0]   in_data;
    logic [NUM_CH-1:0]         in_ready;
    logic                      out_valid;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_sel;
    logic                      out_ready;

    modport slave (
        input  flush, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sel
    );

    modport master (
        output flush, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sel
    );
endinterface

// File: rtl/rr_arb_mux_arbiter.sv
// rtl/rr_arb_mux_arbiter.sv - combinational fixed-priority / round-robin arbiter
module rr_arbiter
    import rr_arb_mux_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int MODE   = ARB_RR,
    localparam int SEL_W = sel_w(NUM_CH)
) (
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    output logic [NUM_CH-1:0] o_grant,
    output logic [SEL_W-1:0]  o_grant_idx
);

    int   w_start;
    int   w_idx;
    logic w_found;

    // Scan from the start point, wrapping, and grant the first requester.
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        w_idx       = 0;
        w_start     = (MODE == ARB_RR) ? int'(i_ptr) : 0;
        for (int k = 0; k < NUM_CH; k++) begin
            w_idx = (w_start + k) % NUM_CH;
            if (!w_found && i_req[w_idx]) begin
                o_grant[w_idx] = 1'b1;
                o_grant_idx    = w_idx[SEL_W-1:0];
                w_found        = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_arb_mux.sv
// rtl/rr_arb_mux.sv - N-channel arbitrating mux with registered output stage
module rr_arb_mux
    import rr_arb_mux_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int NUM_CH   = 4,
    parameter int ARB_MODE = ARB_RR
) (
    input logic          clk,
    input logic          rst_n,
    rr_arb_mux_if.slave  bus
);

    localparam int SEL_W = sel_w(NUM_CH);

    logic              r_out_valid;
    logic [WIDTH-1:0]  r_out_data;
    logic [SEL_W-1:0]  r_out_sel;
    logic [SEL_W-1:0]  r_rr_ptr;

    logic [NUM_CH-1:0] w_grant;
    logic [SEL_W-1:0]  w_grant_idx;
    logic              w_load;
    logic              w_xfer;
    logic [SEL_W-1:0]  w_ptr_next;
    logic [WIDTH-1:0]  w_sel_data;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .MODE   (ARB_MODE)
    ) u_arb (
        .i_req       (bus.in_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx)
    );

    // The register can take new data when empty or being drained, never during flush.
    assign w_load       = !bus.flush && (!r_out_valid || bus.out_ready);
    assign bus.in_ready = w_load ? w_grant : '0;
    assign w_xfer       = w_load && (|w_grant);
    assign w_ptr_next   = (w_grant_idx == SEL_W'(NUM_CH - 1)) ? '0 : w_grant_idx + 1'b1;
    assign w_sel_data   = bus.in_data[int'(w_grant_idx) * WIDTH +: WIDTH];

    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_sel   = r_out_sel;

    // Output register and round-robin pointer; flush beats drain and fill.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_sel   <= '0;
            r_rr_ptr    <= '0;
        end else if (bus.flush) begin
            r_out_valid <= 1'b0;
        end else if (w_xfer) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_sel_data;
            r_out_sel   <= w_grant_idx;
            r_rr_ptr    <= w_ptr_next;
        end else if (bus.out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_arb_mux.sv
// tb/tb_rr_arb_mux.sv - randomized scoreboard bench over several channel/width/mode configs
module tb_rr_arb_mux;
    import rr_arb_mux_pkg::*;

    localparam int NCFG = 5;

    function automatic int cfg_n(input int g);
        case (g) 0: return 4; 1: return 4; 2: return 3; 3: return 2; default: return 16; endcase
    endfunction
    function automatic int cfg_w(input int g);
        case (g) 0: return 32; 1: return 32; 2: return 8; 3: return 8; default: return 16; endcase
    endfunction
    function automatic int cfg_m(input int g);
        return (g == 1) ? ARB_FIXED : ARB_RR;
    endfunction

    logic clk = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int N = cfg_n(g);
        localparam int W = cfg_w(g);
        localparam int M = cfg_m(g);

        logic rst_l;
        rr_arb_mux_if #(.WIDTH(W), .NUM_CH(N)) bus ();
        rr_arb_mux #(.WIDTH(W), .NUM_CH(N), .ARB_MODE(M)) dut (
            .clk   (clk),
            .rst_n (rst_l),
            .bus   (bus)
        );

        logic [W-1:0]  q_data[$];
        int            q_sel[$];
        logic [N-1:0]  exp_ready;
        logic [W-1:0]  p_data;
        int            m_ptr, n_ptr, p_sel, start, idx;
        bit            m_valid, n_valid, p_valid, load, found;

        // Monitor: whatever the output register shows must be the oldest accepted item.
        always @(negedge clk) begin
            if (rst_l) begin
                if (bus.out_valid) begin
                    if (q_data.size() == 0) begin
                        check($sformatf("cfg%0d unexpected_out_valid", g), 64'd1, 64'd0);
                    end else begin
                        check($sformatf("cfg%0d out_data", g), 64'(bus.out_data), 64'(q_data[0]));
                        check($sformatf("cfg%0d out_sel", g), 64'(bus.out_sel), 64'(q_sel[0]));
                        if (bus.out_ready || bus.flush) begin
                            void'(q_data.pop_front());
                            void'(q_sel.pop_front());
                        end
                    end
                end else begin
                    check($sformatf("cfg%0d missing_out_valid", g), 64'(q_data.size()), 64'd0);
                end
            end
        end

        // Stimulus plus reference model of the handshake rules.
        initial begin
            rst_l = 1'b1;
            bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0; bus.flush = 1'b0;
            m_valid = 0; n_valid = 0; p_valid = 0; m_ptr = 0; n_ptr = 0; p_sel = 0; p_data = '0;
            #2 rst_l = 1'b0;
            #1;
            check($sformatf("cfg%0d rst_valid", g), 64'(bus.out_valid), 64'd0);
            check($sformatf("cfg%0d rst_data", g), 64'(bus.out_data), 64'd0);
            check($sformatf("cfg%0d rst_sel", g), 64'(bus.out_sel), 64'd0);
            repeat (2) @(posedge clk);
            #1 rst_l = 1'b1;

            for (int cyc = 0; cyc < 1200; cyc++) begin
                @(posedge clk);
                if (p_valid) begin
                    q_data.push_back(p_data);
                    q_sel.push_back(p_sel);
                end
                m_valid = n_valid;
                m_ptr   = n_ptr;
                p_valid = 0;
                #1;
                if (cyc == 701) rst_l = 1'b1;
                for (int i = 0; i < N; i++) begin
                    bus.in_valid[i] = (cyc < 5) ? 1'b0 : ($urandom_range(0, 99) < 45);
                    bus.in_data[i*W +: W] = W'($urandom);
                end
                bus.out_ready = ($urandom_range(0, 99) < 70);
                bus.flush     = ($urandom_range(0, 99) < 8);
                if (cyc >= 200 && cyc < 216) begin
                    bus.in_valid = '1; bus.out_ready = 1'b1; bus.flush = 1'b0;
                end
                if (cyc >= 300 && cyc < 306) begin
                    bus.out_ready = 1'b0; bus.flush = 1'b0;
                end
                #1;
                load      = !bus.flush && (!m_valid || bus.out_ready);
                exp_ready = '0;
                found     = 0;
                start     = (M == ARB_RR) ? m_ptr : 0;
                for (int k = 0; k < N; k++) begin
                    idx = (start + k) % N;
                    if (!found && load && bus.in_valid[idx]) begin
                        found = 1;
                        exp_ready[idx] = 1'b1;
                        p_sel  = idx;
                        p_data = bus.in_data[idx*W +: W];
                    end
                end
                check($sformatf("cfg%0d in_ready", g), 64'(bus.in_ready), 64'(exp_ready));
                if (found) begin
                    p_valid = 1;
                    n_valid = 1;
                    n_ptr   = (p_sel + 1) % N;
                end else begin
                    n_valid = bus.flush ? 0 : (m_valid && bus.out_ready) ? 0 : m_valid;
                    n_ptr   = m_ptr;
                end
                if (cyc == 700) begin
                    #1 rst_l = 1'b0;
                    #1;
                    check($sformatf("cfg%0d midrst_valid", g), 64'(bus.out_valid), 64'd0);
                    check($sformatf("cfg%0d midrst_data", g), 64'(bus.out_data), 64'd0);
                    check($sformatf("cfg%0d midrst_sel", g), 64'(bus.out_sel), 64'd0);
                    q_data.delete();
                    q_sel.delete();
                    p_valid = 0; n_valid = 0; m_valid = 0; n_ptr = 0; m_ptr = 0;
                end
            end
            done_cnt++;
        end
    end

    initial begin
        for (int t = 0; t < 20000 && done_cnt < NCFG; t++) @(posedge clk);
        if (done_cnt < NCFG) begin
            checks++;
            failures++;
            $display("FAIL timeout: done=%0d required=%0d", done_cnt, NCFG);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rr_arb_mux.md
Name: rr_arb_mux

Overview:
Parametrised N-channel, WIDTH-bit arbitrating multiplexer with a registered output stage and valid/ready handshakes on every channel. Successor to the fixed 4:1 and 8:1 combinational selectors. Used where several pipeline producers (functional units, forwarding sources) compete for one downstream consumer, such as the writeback or commit path. Selection comes from an internal arbiter, fixed-priority or round-robin, instead of an external select.

Parameters:
WIDTH, 32, data width of each channel and of the output.
NUM_CH, 4, number of input channels; legal range 2..16.
ARB_MODE, 1, 0 = fixed priority (lowest index wins); 1 = round-robin.
SEL_W, $clog2(NUM_CH), width of the grant index; derived, not overridden.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst_n  in  1  asynchronous active-low reset.
flush  in  1  synchronous pipeline flush.
in_valid  in  NUM_CH  per-channel request.
in_data  in  NUM_CH*WIDTH  flattened channel data; channel i occupies bits [i*WIDTH +: WIDTH].
in_ready  out  NUM_CH  per-channel accept; combinational.
out_valid  out  1  output register holds valid data.
out_data  out  WIDTH  registered selected data.
out_sel  out  SEL_W  index of the channel that supplied out_data.
out_ready  in  1  downstream accept.

Behaviour:
- Reset (rst_n low, asynchronous): out_valid=0, out_data=0, out_sel=0, round-robin pointer rr_ptr=0. All state reaches these values without a clock edge.
- Load enable: load = !flush && (!out_valid || out_ready).
- Grant: one-hot, combinational from in_valid.
  - ARB_MODE=0: lowest-index asserted channel wins.
  - ARB_MODE=1: search starts at rr_ptr and wraps modulo NUM_CH. The first asserted channel wins.
  - No requests means grant=0.
- in_ready[i] = load && grant[i]. At most one bit is high per cycle. in_ready must not depend on in_data. It may depend on in_valid and out_ready.
- Transfer from channel i happens when in_valid[i] && in_ready[i]. On the next edge: out_data <= channel i data, out_sel <= i, out_valid <= 1.
- Downstream side:
  - When out_valid && out_ready and no new transfer occurs, out_valid <= 0 on the next edge.
  - Back-to-back operation, one transfer per cycle, is sustained while out_ready stays high.
- Holding: when out_valid && !out_ready, out_data and out_sel stay stable and in_ready is all zero.
- Latency: 1 cycle from accepted input to out_valid.
- Round-robin pointer:
  - Updates only on a transfer, to (granted index + 1) mod NUM_CH. Wrap: a grant to NUM_CH-1 sets rr_ptr=0.
  - Unchanged when idle, stalled or flushed.
  - Ignored when ARB_MODE=0.
- flush (synchronous):
  - Next edge: out_valid <= 0.
  - in_ready is all zero during the flush cycle, so no input is consumed.
  - out_data and out_sel keep their old values.
  - rr_ptr is unchanged.
  - flush takes priority over out_ready and over any transfer.
- Simultaneous drain and fill (out_valid && out_ready && a new grant): the register is overwritten with the new data and out_valid stays 1.
- Starvation: in ARB_MODE=1, a continuously asserted channel is granted within NUM_CH transfers.
- Reset mid-transfer: the pending output is discarded and rr_ptr returns to 0.
- No X propagation: with no valid requests, grant is all zero and out_data is not updated.

Decomposition:
- Shared package holds:
  - ARB_FIXED=0 and ARB_RR=1 constants.
  - A clog2-based SEL_W helper function, for reuse with the existing mux selectors.
- One sub-module, rr_arbiter (parameter NUM_CH, MODE). It is combinational: inputs req and ptr, outputs grant (one-hot) and grant_idx.
- rr_arb_mux owns the output register, rr_ptr and the handshake logic.

Test Plan:
- Reset/idle: hold rst_n=0 mid-cycle -> out_valid, out_data, out_sel go to 0 immediately. After release with no requests, in_ready=0000 and out_valid stays 0.
- Fixed priority (ARB_MODE=0, NUM_CH=4): in_valid=1010, out_ready=1 -> in_ready=0010. Next cycle out_sel=1 and out_data=ch1 data (e.g. 32'hA5A5_0001).
- Round-robin fairness (ARB_MODE=1): in_valid=1111 held, out_ready=1 for 8 cycles -> out_sel sequence 0,1,2,3,0,1,2,3 with out_valid continuously 1.
- Backpressure: out_valid=1 and out_ready=0 for 3 cycles while in_valid=0100 -> in_ready=0000, and out_data/out_sel stay stable. When out_ready rises, ch2 is accepted the same cycle and appears the next cycle.
- Flush: assert flush while out_valid=1 and in_valid=0001 -> out_valid=0 next cycle, ch0 not consumed, rr_ptr unchanged. Next cycle ch0 is accepted.
- Wrap and parameter sweep: NUM_CH=3, WIDTH=8, rr_ptr=2 and in_valid=101 -> ch2 granted, rr_ptr wraps to 0, next grant is ch0. Repeat the suite at NUM_CH=2 and 16.
